// File: rtl/sub_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sub_share_arbiter
// Purpose  : Four requesters share one W-bit subtractor (D = A + ~B + 1).
//            A round-robin IDLE/CALC/DONE sequencer grants one requester,
//            captures its operands, computes the result, and returns a
//            one-cycle done pulse. One operation completes every 3 cycles.
// Ports    : clk     - rising-edge clock
//            rst_n   - asynchronous active-low reset
//            req     - [3:0] per-requester request level
//            A_bus   - [4*W-1:0] minuends, requester i at [i*W +: W]
//            B_bus   - [4*W-1:0] subtrahends, requester i at [i*W +: W]
//            done    - [3:0] one-hot completion pulse to the served requester
//            D       - [W-1:0] registered difference
//            borrow  - registered, 1 when A < B (unsigned)
//            zero    - registered, 1 when A == B
//            busy    - 1 while an operation is in CALC or DONE
// Options  : SUB_SAT_EN - when defined, a borrowing subtract loads D = 0.
// Revision : 1.0 - initial release
// ============================================================================
module sub_share_arbiter #(
    parameter int W = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] A_bus,
    input  logic [4*W-1:0] B_bus,
    output logic [3:0]     done,
    output logic [W-1:0]   D,
    output logic           borrow,
    output logic           zero,
    output logic           busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic         w_grant;
    logic         w_calc;
    logic         w_finish;

    logic [1:0]   r_ptr;
    logic [1:0]   r_gnt;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] r_d;
    logic         r_borrow;
    logic         r_zero;
    logic [3:0]   r_done;

    logic [W-1:0] w_a [4];
    logic [W-1:0] w_b [4];
    logic         w_req_any;
    logic [1:0]   w_sel;

    logic [W:0]   w_sum;
    logic [W-1:0] w_diff;
    logic         w_borrow;
    logic         w_equal;
    logic [W-1:0] w_d_result;

    // ------------------------------------------------------------------
    // Operand bus unpacking
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign w_a[gi] = A_bus[gi*W +: W];
            assign w_b[gi] = B_bus[gi*W +: W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin selection: first asserted request at or above r_ptr,
    // wrapping 3 -> 0. Scanning from the farthest offset down lets the
    // nearest asserted requester overwrite the result last.
    // ------------------------------------------------------------------
    assign w_req_any = |req;

    always_comb begin
        w_sel = r_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[r_ptr + 2'(i)]) begin
                w_sel = r_ptr + 2'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Shared subtractor. The carry out of A + ~B + 1 is the inverted
    // borrow; a zero difference only happens for equal operands.
    // ------------------------------------------------------------------
    assign w_sum    = {1'b0, r_a} + {1'b0, ~r_b} + {{W{1'b0}}, 1'b1};
    assign w_diff   = w_sum[W-1:0];
    assign w_borrow = ~w_sum[W];
    assign w_equal  = (w_diff == '0);

`ifdef SUB_SAT_EN
    assign w_d_result = w_borrow ? '0 : w_diff;
`else
    assign w_d_result = w_diff;
`endif

    // ------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer: next state and phase strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_calc      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                w_calc      = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Operands are captured at grant so the requester
    // may change or drop them afterwards. done is registered on the DONE
    // edge, so a reset during CALC or DONE never produces a pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 2'd0;
            r_gnt    <= 2'd0;
            r_a      <= '0;
            r_b      <= '0;
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
            r_done   <= 4'd0;
        end else begin
            r_done <= 4'd0;
            if (w_grant) begin
                r_gnt <= w_sel;
                r_a   <= w_a[w_sel];
                r_b   <= w_b[w_sel];
            end
            if (w_calc) begin
                r_d      <= w_d_result;
                r_borrow <= w_borrow;
                r_zero   <= w_equal;
            end
            if (w_finish) begin
                r_done <= 4'b0001 << r_gnt;
                r_ptr  <= r_gnt + 2'd1;
            end
        end
    end

    assign done   = r_done;
    assign D      = r_d;
    assign borrow = r_borrow;
    assign zero   = r_zero;
    assign busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sub_share_arbiter.md
SUB_SHARE_ARBITER -- requirements
Module: sub_share_arbiter

Interface
REQ-001 Parameters SHALL be: W, 10, operand/result width in bits.
REQ-002 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port req  input  4  per-requester subtract request, level.
REQ-006 Port A_bus  input  4*W  minuends; requester i at bits [i*W +: W].
REQ-007 Port B_bus  input  4*W  subtrahends; requester i at bits [i*W +: W].
REQ-008 Port done  output  4  one-hot, one-cycle completion pulse to the served requester.
REQ-009 Port D  output  W  registered result A-B.
REQ-010 Port borrow  output  1  registered; 1 when A < B (unsigned).
REQ-011 Port zero  output  1  registered; 1 when A == B.
REQ-012 Port busy  output  1  1 while in CALC or DONE.

Function
REQ-013 One internal W-bit subtractor SHALL be shared by all four requesters: D = A + ~B + 1, modulo 2^W; borrow = NOT carry-out.
REQ-014 FSM states SHALL be IDLE, CALC, DONE; the encoding is free.
REQ-015 IDLE: if req != 0, grant the first asserted requester searching from ptr upward with 3->0 wrap; latch its index, A and B; go to CALC. Otherwise stay in IDLE.
REQ-016 CALC: register D, borrow and zero from the latched operands; go to DONE.
REQ-017 DONE: assert done[g] for exactly this cycle; set ptr = (g+1) mod 4; go to IDLE.
REQ-018 Latency: req sampled at edge k SHALL give done visible after edge k+2. Throughput SHALL be one operation per 3 cycles.
REQ-019 Operands are captured at grant. A requester MAY drop req or change operands after grant without affecting the result. done SHALL still be issued.
REQ-020 A requester still holding req after its done SHALL be treated as a new request, subject to round-robin.
REQ-021 When all four request continuously, the grant order SHALL be 0,1,2,3,0,... starting from ptr.
REQ-022 D, borrow and zero SHALL hold their values until the next CALC. They are valid in DONE and afterwards.
REQ-023 Wrap-around: A=0, B=1 SHALL give D=2^W-1 and borrow=1 when saturation is compiled out.
REQ-024 Requests arriving during CALC or DONE SHALL be ignored until IDLE; they are not lost while held.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, ptr=0, done=0, D=0, borrow=0, zero=0 and busy=0.
REQ-026 A reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-027 After release, the first grant SHALL be evaluated at the first rising edge with rst_n=1.

Configuration
REQ-028 Macro SUB_SAT_EN: when defined, a borrow result SHALL load D=0 (saturating subtract). borrow and zero SHALL still report the true comparison; zero SHALL be 0 when borrow=1.
REQ-029 Without SUB_SAT_EN, D SHALL be the modulo-2^W difference.

Verification
REQ-030 Single request: req=0001, A0=700, B0=200 -> done=0001 two edges later, D=500, borrow=0, zero=0, busy=1 for 2 cycles.
REQ-031 All requests held, ptr=0 -> done sequence 0001,0010,0100,1000,0001 spaced 3 cycles apart, each D matching its own operands.
REQ-032 Wrap: A=0, B=1 -> D=1023, borrow=1. With SUB_SAT_EN -> D=0, borrow=1, zero=0.
REQ-033 Equal operands: A=B=513 -> D=0, zero=1, borrow=0.
REQ-034 Operands and req changed one cycle after grant -> result uses the captured values; done still pulses.
REQ-035 rst_n pulled low during CALC -> outputs 0 immediately, no done pulse; after release, req=0100 is served first only if it is the first asserted from ptr=0.
